// File: rtl/fetch_unit.sv
// fetch_unit: PC, branch-target LUT and run/halt sequencing for the instruction-fetch side
module fetch_unit #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [8:0]       Prog_Data,
    input  logic [7:0]       Acc_Data,
    input  logic             PC_Jmp_Flag,
    input  logic             PC_Beq_Flag,
    input  logic             LUT_Write_En,
    input  logic             LUT_Load_Hi,
    input  logic             LUT_Read_En,
    input  logic             Ack,
    output logic [PC_W-1:0]  Prog_Addr,
    output logic [8:0]       Instruction,
    output logic             Exec_En,
    output logic             Done,
    output logic [CNT_W-1:0] Instr_Count
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, HALT} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] lut [2**LUT_AW];
    logic [LUT_AW-1:0] idx;
    logic            unused_read_en;

    assign unused_read_en = LUT_Read_En;
    assign idx         = Prog_Data[LUT_AW-1:0];
    assign Exec_En     = (state == RUN) && !Start;
    assign Instruction = Exec_En ? Prog_Data : 9'h000;
    assign Prog_Addr   = pc;

    // Run/halt sequencing, next-PC selection and retired-instruction counting
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            pc          <= '0;
            Done        <= 1'b0;
            Instr_Count <= '0;
        end else begin
            case (state)
                IDLE:  state <= Start ? ARMED : IDLE;
                ARMED: begin
                    pc          <= '0;
                    Done        <= 1'b0;
                    Instr_Count <= '0;
                    state       <= Start ? ARMED : RUN;
                end
                RUN: begin
                    if (Start) begin
                        state <= ARMED;
                    end else begin
                        Instr_Count <= (Instr_Count == '1) ? Instr_Count : Instr_Count + 1'b1;
                        if (Ack) begin
                            state <= HALT;
                            Done  <= 1'b1;
                        end else begin
                            pc <= (PC_Jmp_Flag || PC_Beq_Flag) ? lut[idx] : pc + 1'b1;
                        end
                    end
                end
                default: state <= Start ? ARMED : HALT;
            endcase
        end
    end

    // Branch-target LUT: half-word writes from the accumulator, cleared only by Reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
        end else if (Exec_En && LUT_Write_En && !Ack) begin
            if (LUT_Load_Hi) lut[idx][PC_W-1:8] <= Acc_Data[PC_W-9:0];
            else lut[idx][7:0] <= Acc_Data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus reset/saturation sequences for fetch_unit
module tb_fetch_unit;
    logic        Clk = 1'b0;
    logic        Reset, Start, PC_Jmp_Flag, PC_Beq_Flag, LUT_Write_En, LUT_Load_Hi, LUT_Read_En, Ack;
    logic [8:0]  Prog_Data;
    logic [7:0]  Acc_Data;
    logic [9:0]  Prog_Addr;
    logic [8:0]  Instruction;
    logic        Exec_En, Done;
    logic [15:0] Instr_Count;

    int checks = 0;
    int failures = 0;
    int cur = -1;

    typedef struct {
        logic        st;
        logic [8:0]  pd;
        logic [7:0]  acc;
        logic        j, b, w, h, a;
        logic [9:0]  pc;
        logic        ex, dn;
        logic [15:0] cnt;
    } vec_t;

    vec_t v[26];

    fetch_unit #(.PC_W(10), .LUT_AW(4), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Prog_Data(Prog_Data), .Acc_Data(Acc_Data),
        .PC_Jmp_Flag(PC_Jmp_Flag), .PC_Beq_Flag(PC_Beq_Flag), .LUT_Write_En(LUT_Write_En),
        .LUT_Load_Hi(LUT_Load_Hi), .LUT_Read_En(LUT_Read_En), .Ack(Ack),
        .Prog_Addr(Prog_Addr), .Instruction(Instruction), .Exec_En(Exec_En), .Done(Done),
        .Instr_Count(Instr_Count)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic st, input logic [8:0] pd, input logic [7:0] acc,
                                input logic j, b, w, h, a, input logic [9:0] pc,
                                input logic ex, dn, input logic [15:0] cnt);
        vec_t r;
        r.st = st; r.pd = pd; r.acc = acc; r.j = j; r.b = b; r.w = w; r.h = h; r.a = a;
        r.pc = pc; r.ex = ex; r.dn = dn; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, cur, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        Start = x.st; Prog_Data = x.pd; Acc_Data = x.acc; PC_Jmp_Flag = x.j; PC_Beq_Flag = x.b;
        LUT_Write_En = x.w; LUT_Load_Hi = x.h; Ack = x.a; LUT_Read_En = x.j | x.b;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        //        st  pd      acc    j  b  w  h  a  pc       ex dn cnt
        v[0]  = mk(1, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 16'd0);
        v[1]  = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 16'd0);
        v[2]  = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h000, 1, 0, 16'd0);
        v[3]  = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h001, 1, 0, 16'd1);
        v[4]  = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h002, 1, 0, 16'd2);
        v[5]  = mk(0, 9'h0A2, 8'h34, 0, 0, 1, 0, 0, 10'h003, 1, 0, 16'd3);
        v[6]  = mk(0, 9'h0A2, 8'h01, 0, 0, 1, 1, 0, 10'h004, 1, 0, 16'd4);
        v[7]  = mk(0, 9'h0C2, 8'h00, 0, 0, 0, 0, 0, 10'h005, 1, 0, 16'd5);
        v[8]  = mk(0, 9'h0E2, 8'h00, 1, 0, 0, 0, 0, 10'h006, 1, 0, 16'd6);
        v[9]  = mk(0, 9'h0C2, 8'h00, 0, 1, 0, 0, 0, 10'h134, 1, 0, 16'd7);
        v[10] = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h134, 1, 0, 16'd8);
        v[11] = mk(0, 9'h1FF, 8'h00, 1, 0, 1, 0, 1, 10'h135, 1, 0, 16'd9);
        v[12] = mk(0, 9'h0A2, 8'hFF, 1, 0, 1, 0, 0, 10'h135, 0, 1, 16'd10);
        v[13] = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h135, 0, 1, 16'd10);
        v[14] = mk(1, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h135, 0, 1, 16'd10);
        v[15] = mk(1, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h135, 0, 1, 16'd10);
        v[16] = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 16'd0);
        v[17] = mk(0, 9'h0E2, 8'h00, 1, 0, 0, 0, 0, 10'h000, 1, 0, 16'd0);
        v[18] = mk(1, 9'h0A2, 8'h55, 1, 0, 1, 0, 0, 10'h134, 0, 0, 16'd1);
        v[19] = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h134, 0, 0, 16'd1);
        v[20] = mk(0, 9'h0E2, 8'h00, 1, 0, 0, 0, 0, 10'h000, 1, 0, 16'd0);
        v[21] = mk(0, 9'h0A3, 8'hFF, 0, 0, 1, 0, 0, 10'h134, 1, 0, 16'd1);
        v[22] = mk(0, 9'h0A3, 8'h03, 0, 0, 1, 1, 0, 10'h135, 1, 0, 16'd2);
        v[23] = mk(0, 9'h0E3, 8'h00, 1, 0, 0, 0, 0, 10'h136, 1, 0, 16'd3);
        v[24] = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h3FF, 1, 0, 16'd4);
        v[25] = mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h000, 1, 0, 16'd5);

        Reset = 1'b1;
        drive(mk(0, 9'h000, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 16'd0));
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_pc", 32'(Prog_Addr), 32'h0);
        chk("rst_exec", 32'(Exec_En), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_cnt", 32'(Instr_Count), 32'h0);

        for (int i = 0; i < 26; i++) begin
            cur = i;
            drive(v[i]);
            #1;
            chk("pc", 32'(Prog_Addr), 32'(v[i].pc));
            chk("exec", 32'(Exec_En), 32'(v[i].ex));
            chk("done", 32'(Done), 32'(v[i].dn));
            chk("cnt", 32'(Instr_Count), 32'(v[i].cnt));
            chk("instr", 32'(Instruction), v[i].ex ? 32'(v[i].pd) : 32'h0);
            tick();
        end

        cur = 100;
        Reset = 1'b1;
        drive(mk(1, 9'h0A2, 8'h77, 0, 0, 1, 0, 0, 10'h000, 0, 0, 16'd0));
        tick();
        Reset = 1'b0;
        drive(mk(0, 9'h012, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 16'd0));
        #1;
        chk("rst_ovr_pc", 32'(Prog_Addr), 32'h0);
        chk("rst_ovr_done", 32'(Done), 32'h0);
        chk("rst_ovr_exec", 32'(Exec_En), 32'h0);
        chk("rst_ovr_cnt", 32'(Instr_Count), 32'h0);
        tick();
        chk("idle_hold_exec", 32'(Exec_En), 32'h0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Prog_Data = 9'h0E2;
        PC_Jmp_Flag = 1'b1;
        #1;
        chk("run_after_rst", 32'(Exec_En), 32'h1);
        tick();
        chk("lut2_cleared", 32'(Prog_Addr), 32'h0);
        chk("cnt_after_jmp", 32'(Instr_Count), 32'h1);

        cur = 101;
        PC_Jmp_Flag = 1'b0;
        Prog_Data = 9'h012;
        for (int k = 0; k < 65540; k++) tick();
        chk("cnt_sat", 32'(Instr_Count), 32'hFFFF);
        chk("sat_exec", 32'(Exec_En), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
